// File: rtl/ahb_mp_sram.sv
// N-port AHB-Lite slave memory with round-robin arbitration, console and test-pass MMIO.
// Optional random grant stalls are enabled with `define AHB_RANDOM_STALL_EN.
module ahb_mp_sram #(
   parameter int                NPORTS       = 2,
   parameter int                DATA_W       = 64,
   parameter int                ADDR_W       = 32,
   parameter int                MEM_BYTES    = 65536,
   parameter int                WAIT_STATES  = 0,
   parameter logic [ADDR_W-1:0] CONSOLE_ADDR = ADDR_W'(32'h1000_0000),
   parameter logic [ADDR_W-1:0] PASS_ADDR    = ADDR_W'(32'h2000_0000)
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [2*NPORTS-1:0]      htrans,
   input  logic [ADDR_W*NPORTS-1:0] haddr,
   input  logic [NPORTS-1:0]        hwrite,
   input  logic [3*NPORTS-1:0]      hsize,
   input  logic [DATA_W*NPORTS-1:0] hwdata,
   output logic [DATA_W*NPORTS-1:0] hrdata,
   output logic [NPORTS-1:0]        hready,
   output logic [NPORTS-1:0]        hresp,
   output logic                     console_valid,
   output logic [7:0]               console_data,
   output logic                     tests_passed
);

   localparam int BPW   = DATA_W / 8;
   localparam int BW    = $clog2(BPW);
   localparam int WORDS = MEM_BYTES / BPW;
   localparam int IW    = $clog2(WORDS);
   localparam int PW    = (NPORTS > 1) ? $clog2(NPORTS) : 1;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_WAIT = 3'd1;
   localparam logic [2:0] ST_PEND = 3'd2;
   localparam logic [2:0] ST_ERR1 = 3'd3;
   localparam logic [2:0] ST_ERR2 = 3'd4;

   logic [2:0]        state_r [NPORTS];
   logic [3:0]        cnt_r   [NPORTS];
   logic [ADDR_W-1:0] addr_r  [NPORTS];
   logic [2:0]        size_r  [NPORTS];
   logic              write_r [NPORTS];
   logic [PW-1:0]     rr_r;
   logic [DATA_W-1:0] mem_r   [WORDS];

   logic [NPORTS-1:0] req_s;
   logic              gnt_valid_s;
   logic [PW-1:0]     gnt_idx_s;
   int                cand_s;
   logic [ADDR_W-1:0] g_addr_s;
   logic              g_write_s;
   logic [2:0]        g_size_s;
   logic [DATA_W-1:0] g_wdata_s;
   logic [DATA_W-1:0] g_rdata_s;
   logic [IW-1:0]     g_word_s;
   logic              g_console_s;
   logic              g_pass_s;
   logic              g_mmio_s;
   logic [BPW-1:0]    g_mask_s;

   // Transfer is illegal if oversized, misaligned, or outside both the array and the MMIO registers.
   function automatic logic addr_err(input logic [ADDR_W-1:0] a, input logic [2:0] sz);
      logic [ADDR_W-1:0] amask_v;
      logic              mmio_v;
      logic              err_v;
      amask_v = (ADDR_W'(1) << sz) - ADDR_W'(1);
      mmio_v  = (a == CONSOLE_ADDR) || (a == PASS_ADDR);
      if (sz > 3'(BW)) begin
         err_v = 1'b1;
      end else if ((a & amask_v) != '0) begin
         err_v = 1'b1;
      end else if (!mmio_v && (a >= ADDR_W'(MEM_BYTES))) begin
         err_v = 1'b1;
      end else begin
         err_v = 1'b0;
      end
      return err_v;
   endfunction

   function automatic logic [BPW-1:0] lane_mask(input logic [BW-1:0] off, input logic [2:0] sz);
      logic [BPW-1:0] base_v;
      base_v = (BPW'(1) << (4'd1 << sz)) - BPW'(1);
      return base_v << off;
   endfunction

`ifdef AHB_RANDOM_STALL_EN
   logic [15:0] lfsr_r;

   // Free-running stall LFSR, x^16+x^14+x^13+x^11+1.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         lfsr_r <= 16'hACE1;
      end else begin
         lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
      end
   end

   // Pending ports request the arbiter unless randomly stalled this cycle.
   always_comb begin
      req_s = '0;
      for (int i = 0; i < NPORTS; i++) begin
         req_s[i] = (state_r[i] == ST_PEND) && !lfsr_r[i];
      end
   end
`else
   // Pending ports request the arbiter.
   always_comb begin
      req_s = '0;
      for (int i = 0; i < NPORTS; i++) begin
         req_s[i] = (state_r[i] == ST_PEND);
      end
   end
`endif

   // Round-robin search starting at rr_r; first requester wins.
   always_comb begin
      gnt_valid_s = 1'b0;
      gnt_idx_s   = '0;
      cand_s      = 0;
      for (int k = 0; k < NPORTS; k++) begin
         cand_s = int'(rr_r) + k;
         cand_s = (cand_s >= NPORTS) ? (cand_s - NPORTS) : cand_s;
         if (req_s[cand_s] && !gnt_valid_s) begin
            gnt_valid_s = 1'b1;
            gnt_idx_s   = PW'(cand_s);
         end else begin
            gnt_valid_s = gnt_valid_s;
         end
      end
   end

   // Steer the granted port's latched request onto the single array port.
   always_comb begin
      g_addr_s    = addr_r[gnt_idx_s];
      g_write_s   = write_r[gnt_idx_s];
      g_size_s    = size_r[gnt_idx_s];
      g_wdata_s   = hwdata[int'(gnt_idx_s)*DATA_W +: DATA_W];
      g_word_s    = g_addr_s[BW +: IW];
      g_rdata_s   = mem_r[g_word_s];
      g_console_s = (g_addr_s == CONSOLE_ADDR);
      g_pass_s    = (g_addr_s == PASS_ADDR);
      g_mmio_s    = g_console_s || g_pass_s;
      g_mask_s    = lane_mask(g_addr_s[BW-1:0], g_size_s);
   end

   // Array write; contents survive reset but nothing commits while reset is asserted.
   always_ff @(posedge clk) begin
      if (resetn && gnt_valid_s && g_write_s && !g_mmio_s) begin
         for (int b = 0; b < BPW; b++) begin
            if (g_mask_s[b]) begin
               mem_r[g_word_s][8*b +: 8] <= g_wdata_s[8*b +: 8];
            end
         end
      end
   end

   // Arbiter pointer and MMIO registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rr_r          <= '0;
         console_valid <= 1'b0;
         console_data  <= 8'h00;
         tests_passed  <= 1'b0;
      end else begin
         console_valid <= 1'b0;
         if (gnt_valid_s) begin
            rr_r <= (int'(gnt_idx_s) == NPORTS - 1) ? '0 : gnt_idx_s + PW'(1);
            if (g_write_s && g_console_s) begin
               console_valid <= 1'b1;
               console_data  <= g_wdata_s[7:0];
            end
            if (g_write_s && g_pass_s && (g_wdata_s[31:0] == 32'd123456789)) begin
               tests_passed <= 1'b1;
            end
         end
      end
   end

   // Per-port transfer FSMs and registered response outputs.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < NPORTS; i++) begin
            state_r[i] <= ST_IDLE;
            cnt_r[i]   <= 4'd0;
            addr_r[i]  <= '0;
            size_r[i]  <= 3'd0;
            write_r[i] <= 1'b0;
         end
         hready <= '1;
         hresp  <= '0;
         hrdata <= '0;
      end else begin
         for (int i = 0; i < NPORTS; i++) begin
            if (hready[i] && htrans[2*i+1]) begin
               addr_r[i]  <= haddr[i*ADDR_W +: ADDR_W];
               size_r[i]  <= hsize[3*i +: 3];
               write_r[i] <= hwrite[i];
               cnt_r[i]   <= 4'(WAIT_STATES);
               hready[i]  <= 1'b0;
               if (addr_err(haddr[i*ADDR_W +: ADDR_W], hsize[3*i +: 3])) begin
                  state_r[i] <= ST_ERR1;
                  hresp[i]   <= 1'b1;
               end else begin
                  state_r[i] <= (WAIT_STATES == 0) ? ST_PEND : ST_WAIT;
                  hresp[i]   <= 1'b0;
               end
            end else begin
               case (state_r[i])
                  ST_IDLE: begin
                     hresp[i] <= 1'b0;
                  end
                  ST_WAIT: begin
                     if (cnt_r[i] <= 4'd1) begin
                        state_r[i] <= ST_PEND;
                     end
                     cnt_r[i] <= cnt_r[i] - 4'd1;
                  end
                  ST_PEND: begin
                     if (gnt_valid_s && (int'(gnt_idx_s) == i)) begin
                        state_r[i] <= ST_IDLE;
                        hready[i]  <= 1'b1;
                        hresp[i]   <= 1'b0;
                        if (!write_r[i]) begin
                           hrdata[i*DATA_W +: DATA_W] <= g_mmio_s ? '0 : g_rdata_s;
                        end
                     end
                  end
                  ST_ERR1: begin
                     state_r[i] <= ST_ERR2;
                     hready[i]  <= 1'b1;
                  end
                  ST_ERR2: begin
                     state_r[i] <= ST_IDLE;
                     hresp[i]   <= 1'b0;
                  end
                  default: begin
                     state_r[i] <= ST_IDLE;
                     hready[i]  <= 1'b1;
                     hresp[i]   <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_ahb_mp_sram.sv
// Directed scoreboard bench for ahb_mp_sram: two 64-bit ports, no wait states.
module tb_ahb_mp_sram;

   localparam int NP = 2;
   localparam int DW = 64;
   localparam int AW = 32;

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic [2*NP-1:0]   htrans = '0;
   logic [AW*NP-1:0]  haddr = '0;
   logic [NP-1:0]     hwrite = '0;
   logic [3*NP-1:0]   hsize = '0;
   logic [DW*NP-1:0]  hwdata = '0;
   logic [DW*NP-1:0]  hrdata;
   logic [NP-1:0]     hready;
   logic [NP-1:0]     hresp;
   logic              console_valid;
   logic [7:0]        console_data;
   logic              tests_passed;

   int          vectors = 0;
   int          miscompares = 0;
   logic [63:0] exp_q[$];
   int          n;

   ahb_mp_sram #(.NPORTS(NP), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .resetn(resetn), .htrans(htrans), .haddr(haddr), .hwrite(hwrite),
      .hsize(hsize), .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp),
      .console_valid(console_valid), .console_data(console_data), .tests_passed(tests_passed)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic addr_phase(input int p, input logic [31:0] a, input logic w, input logic [2:0] sz);
      htrans[2*p +: 2] = 2'b10;
      haddr[AW*p +: AW] = a;
      hwrite[p] = w;
      hsize[3*p +: 3] = sz;
   endtask

   task automatic xfer(input int p, input logic [31:0] a, input logic w, input logic [2:0] sz,
                       input logic [63:0] wd, output int cycles);
      addr_phase(p, a, w, sz);
      step();
      htrans[2*p +: 2] = 2'b00;
      hwdata[DW*p +: DW] = wd;
      cycles = 0;
      while (hready[p] !== 1'b1 && cycles < 64) begin
         step();
         cycles++;
      end
      if (cycles >= 64) check($sformatf("timeout_p%0d", p), 64'(hready[p]), 64'd1);
   endtask

   task automatic rd(input int p, input logic [31:0] a, input logic [63:0] exp, input string tag);
      int c;
      exp_q.push_back(exp);
      xfer(p, a, 1'b0, 3'd3, 64'd0, c);
      check(tag, hrdata[DW*p +: DW], exp_q.pop_front());
      check({tag, "_okay"}, 64'(hresp[p]), 64'd0);
   endtask

   initial begin
      repeat (3) step();
      resetn = 1'b1;
      check("rst_hready", 64'(hready), 64'h3);
      check("rst_hresp", 64'(hresp), 64'h0);
      check("rst_hrdata0", hrdata[63:0], 64'h0);
      check("rst_hrdata1", hrdata[127:64], 64'h0);
      check("rst_console", {55'd0, console_valid, console_data}, 64'h0);
      check("rst_passed", 64'(tests_passed), 64'h0);

      // Single-port write then read, one wait cycle each
      xfer(0, 32'h100, 1'b1, 3'd3, 64'hDEADBEEF_CAFEF00D, n);
      check("wr_latency", 64'(n), 64'd1);
      exp_q.push_back(64'hDEADBEEF_CAFEF00D);
      xfer(0, 32'h100, 1'b0, 3'd3, 64'd0, n);
      check("rd_latency", 64'(n), 64'd1);
      check("rd_0x100", hrdata[63:0], exp_q.pop_front());

      // Sub-word writes touch only their lanes
      xfer(1, 32'h103, 1'b1, 3'd0, 64'h0000_0000_A500_0000, n);
      rd(1, 32'h100, 64'hDEADBEEF_A5FEF00D, "byte_lane3");
      xfer(1, 32'h106, 1'b1, 3'd1, 64'h1234_0000_0000_0000, n);
      rd(1, 32'h100, 64'h1234BEEF_A5FEF00D, "half_lane6");

      // Contention with rr=0: port0 first, then port1
      addr_phase(0, 32'h100, 1'b0, 3'd3);
      addr_phase(1, 32'h100, 1'b0, 3'd3);
      exp_q.push_back(64'h1234BEEF_A5FEF00D);
      exp_q.push_back(64'h1234BEEF_A5FEF00D);
      step();
      htrans = '0;
      check("pairA_accept", 64'(hready), 64'h0);
      step();
      check("pairA_first", 64'(hready), 64'h1);
      check("pairA_p0data", hrdata[63:0], exp_q.pop_front());
      step();
      check("pairA_second", 64'(hready), 64'h3);
      check("pairA_p1data", hrdata[127:64], exp_q.pop_front());

      // Write on port0 and read on port1 in the same cycle: read sees new data
      addr_phase(0, 32'h100, 1'b1, 3'd3);
      addr_phase(1, 32'h100, 1'b0, 3'd3);
      exp_q.push_back(64'h01234567_89ABCDEF);
      step();
      htrans = '0;
      hwdata[63:0] = 64'h01234567_89ABCDEF;
      step();
      check("pairB_first", 64'(hready), 64'h1);
      step();
      check("pairB_second", 64'(hready), 64'h3);
      check("pairB_raw", hrdata[127:64], exp_q.pop_front());

      // Moving rr to 1 makes port1 win the next tie
      rd(0, 32'h100, 64'h01234567_89ABCDEF, "rr_move");
      addr_phase(0, 32'h100, 1'b0, 3'd3);
      addr_phase(1, 32'h100, 1'b0, 3'd3);
      step();
      htrans = '0;
      step();
      check("pairC_first", 64'(hready), 64'h2);
      step();
      check("pairC_second", 64'(hready), 64'h3);

      // Out-of-range read: ERR1 then ERR2 then back to OKAY
      addr_phase(0, 32'h0002_0000, 1'b0, 3'd3);
      step();
      htrans = '0;
      check("err_range_1", {62'd0, hresp[0], hready[0]}, 64'h2);
      step();
      check("err_range_2", {62'd0, hresp[0], hready[0]}, 64'h3);
      step();
      check("err_range_3", {62'd0, hresp[0], hready[0]}, 64'h1);
      // Misaligned word write and oversized read
      xfer(1, 32'h102, 1'b1, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, n);
      check("err_misalign", 64'(hresp[1]), 64'd1);
      step();
      xfer(0, 32'h100, 1'b0, 3'd4, 64'd0, n);
      check("err_size", 64'(hresp[0]), 64'd1);
      step();
      rd(0, 32'h100, 64'h01234567_89ABCDEF, "err_no_effect");

      // Console and pass registers
      xfer(0, 32'h1000_0000, 1'b1, 3'd0, 64'h41, n);
      check("console_pulse", {55'd0, console_valid, console_data}, 64'h141);
      step();
      check("console_clear", 64'(console_valid), 64'd0);
      rd(1, 32'h1000_0000, 64'd0, "mmio_read");
      xfer(1, 32'h2000_0000, 1'b1, 3'd2, 64'd123456788, n);
      check("pass_wrong", 64'(tests_passed), 64'd0);
      xfer(1, 32'h2000_0000, 1'b1, 3'd2, 64'd123456789, n);
      check("pass_set", 64'(tests_passed), 64'd1);
      step();
      check("pass_sticky", 64'(tests_passed), 64'd1);

      // Reset while a write to 0x200 is pending
      xfer(0, 32'h200, 1'b1, 3'd3, 64'h1111, n);
      addr_phase(0, 32'h200, 1'b1, 3'd3);
      step();
      htrans = '0;
      hwdata[63:0] = 64'h2222;
      resetn = 1'b0;
      step();
      check("midrst_hready", 64'(hready), 64'h3);
      check("midrst_hresp", 64'(hresp), 64'h0);
      check("midrst_passed", 64'(tests_passed), 64'd0);
      step();
      resetn = 1'b1;
      rd(0, 32'h200, 64'h1111, "midrst_mem");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
